// File: rtl/pipo_univ_shift.sv
`default_nettype none
// ============================================================================
//  Module      : pipo_univ_shift
//  Description : WIDTH-bit universal register. Supports hold, parallel load,
//                serial shift left/right, rotate left/right and synchronous
//                clear. A shift counter tracks consecutive same-direction
//                shifts and pulses word_done when a full WIDTH-bit serial word
//                has passed, for serial<->parallel conversion.
//  Ports       : clk        rising-edge clock
//                rst_       asynchronous active-high reset
//                en         cycle enable (0 -> state held, word_done low)
//                mode[2:0]  000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//                           100 ROL, 101 ROR, 110 CLR, 111 reserved (HOLD)
//                d_in       parallel load data
//                s_in       serial input bit
//                q_out      register contents
//                s_out      registered bit shifted out by the last SHL/SHR
//                shift_cnt  consecutive same-direction shifts mod WIDTH
//                word_done  one-cycle pulse when the count wraps to 0
//  Revision    : 1.0  initial release
// ============================================================================
module pipo_univ_shift #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         d_in,
    input  logic                     s_in,
    output logic [WIDTH-1:0]         q_out,
    output logic                     s_out,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     word_done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;

    localparam logic          c_DIR_LEFT  = 1'b0;
    localparam logic          c_DIR_RIGHT = 1'b1;
    localparam logic [CW-1:0] c_CNT_MAX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

    logic [WIDTH-1:0] r_data_q, w_data_d;
    logic             r_sout_q, w_sout_d;
    logic [CW-1:0]    r_cnt_q,  w_cnt_d;
    logic             r_dir_q,  w_dir_d;
    logic             r_done_q, w_done_d;

    logic             w_is_shift;
    logic             w_shift_dir;

    always_comb begin
        w_data_d    = r_data_q;
        w_sout_d    = r_sout_q;
        w_cnt_d     = r_cnt_q;
        w_dir_d     = r_dir_q;
        w_done_d    = 1'b0;
        w_is_shift  = 1'b0;
        w_shift_dir = c_DIR_LEFT;

        if (en) begin
            case (mode)
                c_MODE_LOAD: begin
                    w_data_d = d_in;
                    w_cnt_d  = '0;
                end
                c_MODE_SHL: begin
                    w_data_d    = {r_data_q[WIDTH-2:0], s_in};
                    w_sout_d    = r_data_q[WIDTH-1];
                    w_is_shift  = 1'b1;
                    w_shift_dir = c_DIR_LEFT;
                end
                c_MODE_SHR: begin
                    w_data_d    = {s_in, r_data_q[WIDTH-1:1]};
                    w_sout_d    = r_data_q[0];
                    w_is_shift  = 1'b1;
                    w_shift_dir = c_DIR_RIGHT;
                end
                c_MODE_ROL: w_data_d = {r_data_q[WIDTH-2:0], r_data_q[WIDTH-1]};
                c_MODE_ROR: w_data_d = {r_data_q[0], r_data_q[WIDTH-1:1]};
                c_MODE_CLR: begin
                    w_data_d = RESET_VAL;
                    w_cnt_d  = '0;
                end
                // HOLD and the reserved code leave everything as is.
                default: ;
            endcase

            if (w_is_shift) begin
                if (w_shift_dir != r_dir_q) begin
                    // A reversal starts a new word; this shift is its first bit.
                    w_cnt_d = c_CNT_ONE;
                    w_dir_d = w_shift_dir;
                end else if (r_cnt_q == c_CNT_MAX) begin
                    w_cnt_d  = '0;
                    w_done_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_data_q <= RESET_VAL;
            r_sout_q <= 1'b0;
            r_cnt_q  <= '0;
            r_dir_q  <= c_DIR_LEFT;
            r_done_q <= 1'b0;
        end else begin
            r_data_q <= w_data_d;
            r_sout_q <= w_sout_d;
            r_cnt_q  <= w_cnt_d;
            r_dir_q  <= w_dir_d;
            r_done_q <= w_done_d;
        end
    end

    assign q_out     = r_data_q;
    assign s_out     = r_sout_q;
    assign shift_cnt = r_cnt_q;
    assign word_done = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pipo_univ_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipo_univ_shift
//  Description : Self-checking bench for pipo_univ_shift (WIDTH=4,
//                RESET_VAL=0). An arithmetic reference model tracks the
//                register value, the serial output and the length of the
//                current same-direction shift run; a compare process checks
//                the DUT against it every cycle. Directed scenarios pin the
//                model with literal values, then random traffic follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipo_univ_shift;

    localparam int W = 4;

    logic         clk;
    logic         rst_;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d_in;
    logic         s_in;
    logic [W-1:0] q_out;
    logic         s_out;
    logic [1:0]   shift_cnt;
    logic         word_done;

    int checks   = 0;
    int failures = 0;

    pipo_univ_shift #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .en        (en),
        .mode      (mode),
        .d_in      (d_in),
        .s_in      (s_in),
        .q_out     (q_out),
        .s_out     (s_out),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // m_run is the length of the current unbroken same-direction shift run;
    // the visible counter is that length mod W, and a word completes whenever
    // the run length reaches a multiple of W.
    int m_q;
    int m_s;
    int m_run;
    int m_dir;   // 0 = left, 1 = right
    int m_done;

    function automatic int run_after(int run, int cur_dir, int new_dir);
        return (cur_dir == new_dir) ? run + 1 : 1;
    endfunction

    always @(posedge clk or posedge rst_) begin
        if (rst_) begin
            m_q <= 0; m_s <= 0; m_run <= 0; m_dir <= 0; m_done <= 0;
        end else if (!en) begin
            m_done <= 0;
        end else begin
            m_done <= 0;
            case (mode)
                3'd1: begin m_q <= int'(d_in); m_run <= 0; end
                3'd2: begin
                    m_q    <= (m_q * 2) % 16 + int'(s_in);
                    m_s    <= m_q / 8;
                    m_run  <= run_after(m_run, m_dir, 0);
                    m_dir  <= 0;
                    m_done <= (run_after(m_run, m_dir, 0) % W == 0) ? 1 : 0;
                end
                3'd3: begin
                    m_q    <= m_q / 2 + int'(s_in) * 8;
                    m_s    <= m_q % 2;
                    m_run  <= run_after(m_run, m_dir, 1);
                    m_dir  <= 1;
                    m_done <= (run_after(m_run, m_dir, 1) % W == 0) ? 1 : 0;
                end
                3'd4: m_q <= (m_q * 2) % 16 + m_q / 8;
                3'd5: m_q <= m_q / 2 + (m_q % 2) * 8;
                3'd6: begin m_q <= 0; m_run <= 0; end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (int'(q_out) != m_q || int'(s_out) != m_s ||
            int'(shift_cnt) != m_run % W || int'(word_done) != m_done) begin
            failures++;
            $display("FAIL model t=%0t got q=%b s=%b cnt=%0d done=%b exp q=%0d s=%0d cnt=%0d done=%0d",
                     $time, q_out, s_out, shift_cnt, word_done, m_q, m_s, m_run % W, m_done);
        end
    end

    // ---------------- helpers ----------------
    task automatic pin(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and return
    // at the next falling edge, with the resulting state visible.
    task automatic cyc(input logic e, input logic [2:0] m, input logic [W-1:0] d, input logic s);
        en = e; mode = m; d_in = d; s_in = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL = 3'd4, ROR = 3'd5, CLR = 3'd6, RSV = 3'd7;

    initial begin
        rst_ = 1'b1; en = 1'b0; mode = HOLD; d_in = '0; s_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b0;

        // Async reset mid-run, observed before the next rising edge.
        cyc(1, LOAD, 4'b1010, 0);
        cyc(1, SHL, 4'b0000, 1);
        pin("pre_reset_q", int'(q_out), 4'b0101);
        #2 rst_ = 1'b1;
        #1;
        pin("reset_q", int'(q_out), 0);
        pin("reset_cnt", int'(shift_cnt), 0);
        pin("reset_done", int'(word_done), 0);
        #1 rst_ = 1'b0;
        @(negedge clk);

        // Load, hold, and enable gating.
        cyc(1, LOAD, 4'b0111, 0);
        repeat (3) cyc(1, HOLD, 4'b0000, 1);
        pin("hold_q", int'(q_out), 4'b0111);
        cyc(0, LOAD, 4'b1001, 0);
        pin("en_low_q", int'(q_out), 4'b0111);

        // Serial-in word, word_done pulse and its period.
        cyc(1, CLR, 4'b0000, 0);
        cyc(1, SHL, 4'b0000, 1);
        cyc(1, SHL, 4'b0000, 0);
        cyc(1, SHL, 4'b0000, 0);
        pin("shl3_done", int'(word_done), 0);
        cyc(1, SHL, 4'b0000, 1);
        pin("shl4_q", int'(q_out), 4'b1001);
        pin("shl4_done", int'(word_done), 1);
        pin("shl4_cnt", int'(shift_cnt), 0);
        cyc(1, SHL, 4'b0000, 0);
        pin("shl5_done", int'(word_done), 0);
        cyc(1, SHL, 4'b0000, 0);
        cyc(1, SHL, 4'b0000, 0);
        cyc(1, SHL, 4'b0000, 0);
        pin("shl8_done", int'(word_done), 1);

        // Right shifts, direction reversal.
        cyc(1, LOAD, 4'b1011, 0);
        cyc(1, SHR, 4'b0000, 0);
        pin("shr1_sout", int'(s_out), 1);
        pin("shr1_cnt", int'(shift_cnt), 1);
        cyc(1, SHR, 4'b0000, 0);
        pin("shr2_q", int'(q_out), 4'b0010);
        pin("shr2_sout", int'(s_out), 1);
        pin("shr2_cnt", int'(shift_cnt), 2);
        cyc(1, SHL, 4'b0000, 0);
        pin("rev_cnt", int'(shift_cnt), 1);
        pin("rev_done", int'(word_done), 0);

        // Rotates and clear.
        cyc(1, LOAD, 4'b1001, 0);
        cyc(1, ROL, 4'b0000, 0);
        pin("rol_q", int'(q_out), 4'b0011);
        cyc(1, ROR, 4'b0000, 0);
        cyc(1, ROR, 4'b0000, 0);
        pin("ror_q", int'(q_out), 4'b1100);
        pin("rot_cnt", int'(shift_cnt), 0);
        cyc(1, CLR, 4'b0000, 0);
        pin("clr_q", int'(q_out), 0);

        // Abandoned partial word, reserved mode.
        repeat (3) cyc(1, SHL, 4'b0000, 1);
        pin("partial_cnt", int'(shift_cnt), 3);
        cyc(1, LOAD, 4'b1111, 0);
        cyc(1, SHL, 4'b0000, 1);
        pin("abandon_done", int'(word_done), 0);
        pin("abandon_cnt", int'(shift_cnt), 1);
        cyc(1, RSV, 4'b0000, 0);
        pin("rsv_q", int'(q_out), 4'b1111);

        // Random traffic, biased toward shifts so words complete often.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] m;
            if ($urandom_range(0, 1) == 0)
                m = ($urandom_range(0, 3) == 0) ? SHR : SHL;
            else
                m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_ = 1'b1;
                #2 rst_ = 1'b0;
            end
            cyc(($urandom_range(0, 4) != 0), m, 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
